register_file_32: RTL and testbench

- 32-entry, N-bit register file with one synchronous write port and two combinational read ports.
- Read data is selected with two instances of the team's 32:1 `mux32` block (5-bit select).
- Supports an optional write-to-read bypass and a hardware bulk-clear engine that zeroes all entries over 32 cycles.
- Sits directly upstream of the 32:1 read-select stage in the datapath, which consumes its register outputs.

---
 rtl/register_file_pkg.sv | 12 +
 rtl/register_file_32_mux32.sv | 15 +
 rtl/register_file_32.sv | 110 +++++++++++
 tb/tb_register_file_32.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared constants and state type for the 32-entry register file.
package register_file_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } clear_state_t;

endpackage

// File: rtl/register_file_32_mux32.sv
// 32:1 read-select mux over a flattened bank of W-bit words.
module mux32 #(
  parameter int W = 32
) (
  input  logic [32*W-1:0] data_i,
  input  logic [4:0]      sel_i,
  output logic [W-1:0]    data_o
);

  // Pick word sel_i out of the flattened bank.
  always_comb begin
    data_o = data_i[sel_i*W +: W];
  end

endmodule

// File: rtl/register_file_32.sv
// 32-entry register file: one synchronous write port, two combinational read
// ports, optional write-to-read bypass, hardwired-zero entry 0 and a bulk-clear
// engine that zeroes one entry per cycle over 32 cycles.
module register_file_32
  import register_file_pkg::*;
#(
  parameter int N        = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_ena,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [N-1:0]        wr_data,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   rd_addr0,
  output logic [N-1:0]        rd_data0,
  input  logic [ADDR_W-1:0]   rd_addr1,
  output logic [N-1:0]        rd_data1,
  input  logic                clr_req,
  output logic                busy
);

  clear_state_t          state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic [N-1:0]          regs_q [NUM_REGS];
  logic [NUM_REGS*N-1:0] regs_flat;
  logic [N-1:0]          mux_data0, mux_data1;
  logic                  clearing;
  logic                  wr_accept;

  assign clearing  = (state_q == S_CLEAR);
  // Writes to entry 0 are discarded when it is hardwired to zero, so the
  // bypass path can never forward a value into a read of entry 0.
  assign wr_accept = wr_ena && !clearing && !(ZERO_REG && (wr_addr == '0));

  // Clear-engine state and entry counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear-engine next state: clr_req is only honoured from idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (clr_req) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Clear-engine outputs.
  always_comb begin
    busy     = clearing;
    wr_ready = !clearing;
  end

  // Storage: clearing and accepted writes are mutually exclusive by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (clearing) begin
      regs_q[cnt_q] <= '0;
    end else if (wr_accept) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Flatten the array into the mux input bus.
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_flat[i*N +: N] = regs_q[i];
  end

  mux32 #(.W(N)) u_mux_rd0 (
    .data_i (regs_flat),
    .sel_i  (rd_addr0),
    .data_o (mux_data0)
  );

  mux32 #(.W(N)) u_mux_rd1 (
    .data_i (regs_flat),
    .sel_i  (rd_addr1),
    .data_o (mux_data1)
  );

  // Post-mux overrides: same-cycle write forwarding, then hardwired zero.
  always_comb begin
    rd_data0 = mux_data0;
    rd_data1 = mux_data1;
    if (BYPASS && wr_accept && (wr_addr == rd_addr0)) rd_data0 = wr_data;
    else if (ZERO_REG && (rd_addr0 == '0))           rd_data0 = '0;
    if (BYPASS && wr_accept && (wr_addr == rd_addr1)) rd_data1 = wr_data;
    else if (ZERO_REG && (rd_addr1 == '0))           rd_data1 = '0;
  end

endmodule

// File: tb/tb_register_file_32.sv
// Randomized and directed bench for register_file_32 against a behavioural model.
module tb_register_file_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic [4:0]  rd_addr0, rd_addr1;
  logic [31:0] rd_data0, rd_data1;
  logic        clr_req;
  logic        busy;

  register_file_32 #(.N(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_addr0 (rd_addr0),
    .rd_data0 (rd_data0),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1),
    .clr_req  (clr_req),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference model: register contents plus "clear in progress, N entries done".
  logic [31:0] mem [32];
  bit          clr_on;
  int          clr_done;
  int          checks = 0;
  int          errors = 0;
  logic        busy_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit accepted();
    return wr_ena && !clr_on && (wr_addr != 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (accepted() && wr_addr == a) return wr_data;
    if (a == 5'd0) return 32'd0;
    return mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    clr_on   = 1'b0;
    clr_done = 0;
  endtask

  // One clock: check combinational outputs mid-cycle, then advance model on the edge.
  task automatic cycle();
    bit          acc;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          cr;
    @(negedge clk);
    chk("busy", {31'd0, busy}, {31'd0, clr_on});
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, !clr_on});
    chk("rd_data0", rd_data0, exp_rd(rd_addr0));
    chk("rd_data1", rd_data1, exp_rd(rd_addr1));
    busy_seen = busy;
    acc = accepted();
    wa  = wr_addr;
    wd  = wr_data;
    cr  = clr_req;
    @(posedge clk);
    if (rst_n) begin
      if (clr_on) begin
        mem[clr_done] = 32'd0;
        clr_done++;
        if (clr_done == 32) clr_on = 1'b0;
      end else begin
        if (acc) mem[wa] = wd;
        if (cr) begin
          clr_on   = 1'b1;
          clr_done = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    wr_ena  = 1'b0;
    wr_addr = 5'd0;
    wr_data = 32'd0;
    clr_req = 1'b0;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    wr_ena  = 1'b1;
    wr_addr = a;
    wr_data = d;
    cycle();
    wr_ena  = 1'b0;
  endtask

  int busy_cnt;

  initial begin
    model_reset();
    rst_n    = 1'b0;
    idle_inputs();
    rd_addr0 = 5'd0;
    rd_addr1 = 5'd0;

    // Reset state.
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    #10;
    rst_n = 1'b1;
    #1;

    // Read every address on both ports after reset.
    for (int a = 0; a < 32; a++) begin
      rd_addr0 = 5'(a);
      rd_addr1 = 5'(31 - a);
      cycle();
    end

    // Bypass in the write cycle, then registered readback.
    rd_addr0 = 5'd5;
    rd_addr1 = 5'd5;
    wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    #1;
    chk("bypass_rd0", rd_data0, 32'hDEADBEEF);
    cycle();
    wr_ena = 1'b0;
    #1;
    chk("readback_rd0", rd_data0, 32'hDEADBEEF);
    chk("readback_rd1", rd_data1, 32'hDEADBEEF);
    cycle();

    // Writes to entry 0 are discarded.
    rd_addr0 = 5'd0;
    write(5'd0, 32'h12345678);
    cycle();
    chk("zero_reg", rd_data0, 32'd0);

    // Fill 1..31 with their address, then clear.
    for (int a = 1; a < 32; a++) write(5'(a), 32'(a));
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 10) begin rd_addr0 = 5'd20; rd_addr1 = 5'd3; end
      else begin rd_addr0 = 5'($urandom_range(31)); rd_addr1 = 5'($urandom_range(31)); end
      if (k == 12) begin wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'hFF; end
      else wr_ena = 1'b0;
      #1;
      if (k == 10) begin
        chk("midclr_a20", rd_data0, 32'd20);
        chk("midclr_a3", rd_data1, 32'd0);
      end
      if (k == 12) chk("drop_wr_ready", {31'd0, wr_ready}, 32'd0);
      cycle();
      if (busy_seen) busy_cnt++;
    end
    wr_ena = 1'b0;
    chk("busy_len", 32'(busy_cnt), 32'd32);
    for (int a = 0; a < 32; a++) begin
      rd_addr0 = 5'(a);
      rd_addr1 = 5'(a);
      #1;
      chk("post_clear", rd_data0, 32'd0);
      cycle();
    end

    // Clear and write in the same cycle; second clr_req mid-clear ignored.
    clr_req = 1'b1; wr_ena = 1'b1; wr_addr = 5'd9; wr_data = 32'hAA;
    cycle();
    idle_inputs();
    busy_cnt = 0;
    rd_addr0 = 5'd9;
    for (int k = 1; k <= 40; k++) begin
      clr_req = (k == 4);
      cycle();
      if (busy_seen) busy_cnt++;
    end
    clr_req = 1'b0;
    chk("busy_len2", 32'(busy_cnt), 32'd32);
    chk("a9_cleared", rd_data0, 32'd0);

    // Reset in the middle of a clear.
    write(5'd31, 32'h55);
    rd_addr0 = 5'd31;
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_a31", rd_data0, 32'd0);
    #1;
    rst_n = 1'b1;
    write(5'd31, 32'h1);
    cycle();
    chk("post_rst_a31", rd_data0, 32'h1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      wr_ena   = ($urandom_range(3) != 0);
      wr_addr  = 5'($urandom_range(31));
      wr_data  = $urandom;
      rd_addr0 = ($urandom_range(3) == 0) ? wr_addr : 5'($urandom_range(31));
      rd_addr1 = 5'($urandom_range(31));
      clr_req  = ($urandom_range(60) == 0);
      cycle();
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
